// File: rtl/vga_pkg.sv
// VGA 640x480@60 shared timing constants and pixel/coordinate types.
// Latency: n/a (package only).
// Backpressure: n/a.
// Imported by the scan generator, its interface and the screen renderers.
package vga_pkg;

  // Default 640x480@60 timing, in pixels / lines.
  localparam int DEF_H_VIS  = 640;
  localparam int DEF_H_FP   = 16;
  localparam int DEF_H_SYNC = 96;
  localparam int DEF_H_BP   = 48;
  localparam int DEF_V_VIS  = 480;
  localparam int DEF_V_FP   = 10;
  localparam int DEF_V_SYNC = 2;
  localparam int DEF_V_BP   = 33;

  localparam int H_TOTAL      = DEF_H_VIS + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;  // 800
  localparam int V_TOTAL      = DEF_V_VIS + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;  // 525
  localparam int H_SYNC_START = DEF_H_VIS + DEF_H_FP;                          // 656
  localparam int H_SYNC_END   = H_SYNC_START + DEF_H_SYNC;                     // 752
  localparam int V_SYNC_START = DEF_V_VIS + DEF_V_FP;                          // 490
  localparam int V_SYNC_END   = V_SYNC_START + DEF_V_SYNC;                     // 492

  typedef logic [9:0]  coord_t;
  typedef logic [23:0] rgb_t;

endpackage

// File: rtl/vga_scan_gen_if.sv
// Scan-generator <-> renderer/DAC bundle.
// Latency: n/a (wiring only).
// Backpressure: none; the raster is free-running.
// master = scan generator (drives coords, sync, RGB); slave = renderer/DAC side
// (drives color_in for the current x/y).
interface vga_scan_gen_if;
  import vga_pkg::*;

  rgb_t       color_in;    // {R,G,B} for current x/y, combinational in x/y
  coord_t     x;           // horizontal counter
  coord_t     y;           // vertical counter
  logic       active;      // x/y inside the visible area
  logic       pix_en;      // pixel strobe
  logic       frame_tick;  // one-clk pulse at start of vertical blanking
  logic       hsync;       // negative polarity
  logic       vsync;       // negative polarity
  logic       blank_n;     // high on visible pixels
  logic [7:0] vga_r;
  logic [7:0] vga_g;
  logic [7:0] vga_b;

  modport master (
    input  color_in,
    output x, y, active, pix_en, frame_tick,
    output hsync, vsync, blank_n, vga_r, vga_g, vga_b
  );

  modport slave (
    output color_in,
    input  x, y, active, pix_en, frame_tick,
    input  hsync, vsync, blank_n, vga_r, vga_g, vga_b
  );

endinterface

// File: rtl/scan_axis_counter.sv
// One raster axis counter: counts 0..TOTAL-1 on step_i, wraps to 0.
// Latency: count updates on the clk edge where step_i is high.
// Backpressure: none; wrap_o is a same-cycle decode (step_i at terminal count).
// Ports: clk, rst_n, step_i (advance), cnt_o (registered count), wrap_o.
module scan_axis_counter
  import vga_pkg::*;
#(
  parameter int TOTAL = 800
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   step_i,
  output coord_t cnt_o,
  output logic   wrap_o
);

  coord_t cnt_q, cnt_d;
  logic   at_end;

  assign at_end = (cnt_q == coord_t'(TOTAL - 1));
  assign wrap_o = step_i & at_end;

  always_comb begin
    cnt_d = cnt_q;
    if (step_i) begin
      cnt_d = at_end ? '0 : cnt_q + coord_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_scan_gen.sv
// VGA raster scan generator + registered pixel output stage.
// Latency: RGB/hsync/vsync/blank_n lag x/y by exactly one pixel (one pix_en).
// Backpressure: none; free-running, all outputs hold between pix_en strobes.
// Ports: clk, rst_n (async active-low), vga (vga_scan_gen_if.master).
// Build option VGA_PIX_DIV2_EN: pix_en toggles every clk (clk = 2x pixel rate);
// undefined, pix_en is 1 out of reset and clk is the pixel clock.
module vga_scan_gen
  import vga_pkg::*;
#(
  parameter int H_VIS  = DEF_H_VIS,
  parameter int H_FP   = DEF_H_FP,
  parameter int H_SYNC = DEF_H_SYNC,
  parameter int H_BP   = DEF_H_BP,
  parameter int V_VIS  = DEF_V_VIS,
  parameter int V_FP   = DEF_V_FP,
  parameter int V_SYNC = DEF_V_SYNC,
  parameter int V_BP   = DEF_V_BP
) (
  input  logic           clk,
  input  logic           rst_n,
  vga_scan_gen_if.master vga
);

  localparam int H_TOT    = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT    = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int HS_START = H_VIS + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_VIS + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  // Counters are 10 bits wide; larger totals cannot be represented.
  if (H_TOT > 1023 || V_TOT > 1023) begin : g_total_check
    $error("vga_scan_gen: line/frame total exceeds 1023");
  end

  // Pixel strobe.
  logic pix_en_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_en_q <= 1'b0;
    end else begin
`ifdef VGA_PIX_DIV2_EN
      pix_en_q <= ~pix_en_q;
`else
      pix_en_q <= 1'b1;
`endif
    end
  end

  // Raster counters; vertical steps on the horizontal wrap.
  coord_t h_cnt, v_cnt;
  logic   h_wrap, v_wrap;

  scan_axis_counter #(.TOTAL(H_TOT)) u_h_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (pix_en_q),
    .cnt_o  (h_cnt),
    .wrap_o (h_wrap)
  );

  scan_axis_counter #(.TOTAL(V_TOT)) u_v_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .step_i (h_wrap),
    .cnt_o  (v_cnt),
    .wrap_o (v_wrap)
  );

  // Coordinates after the current step; used to register `active` so it lines
  // up with the new x/y without a combinational path from the counters.
  coord_t x_d, y_d;

  always_comb begin
    x_d = h_wrap ? '0 : h_cnt + coord_t'(1);
    y_d = v_cnt;
    if (h_wrap) begin
      y_d = v_wrap ? '0 : v_cnt + coord_t'(1);
    end
  end

  // Output stage: everything sampled on the same pix_en so colour and sync
  // carry the same one-pixel delay.
  logic active_q, blank_n_q, hsync_q, vsync_q, frame_tick_q;
  rgb_t rgb_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q     <= 1'b1;   // counters reset to (0,0), which is visible
      blank_n_q    <= 1'b0;
      hsync_q      <= 1'b1;
      vsync_q      <= 1'b1;
      rgb_q        <= '0;
      frame_tick_q <= 1'b0;
    end else begin
      // Stepping off the last visible line onto (0, V_VIS).
      frame_tick_q <= h_wrap & (v_cnt == coord_t'(V_VIS - 1));
      if (pix_en_q) begin
        active_q  <= (x_d < coord_t'(H_VIS)) && (y_d < coord_t'(V_VIS));
        blank_n_q <= active_q;
        rgb_q     <= active_q ? vga.color_in : '0;
        hsync_q   <= !((h_cnt >= coord_t'(HS_START)) && (h_cnt < coord_t'(HS_END)));
        vsync_q   <= !((v_cnt >= coord_t'(VS_START)) && (v_cnt < coord_t'(VS_END)));
      end
    end
  end

  assign vga.x          = h_cnt;
  assign vga.y          = v_cnt;
  assign vga.active     = active_q;
  assign vga.pix_en     = pix_en_q;
  assign vga.frame_tick = frame_tick_q;
  assign vga.hsync      = hsync_q;
  assign vga.vsync      = vsync_q;
  assign vga.blank_n    = blank_n_q;
  assign vga.vga_r      = rgb_q[23:16];
  assign vga.vga_g      = rgb_q[15:8];
  assign vga.vga_b      = rgb_q[7:0];

endmodule

// File: tb/tb_vga_scan_gen.sv
// Testbench for vga_scan_gen with a reduced raster so several frames fit in a
// short run. The reference model derives every expected output from the
// number of pixel steps taken since reset using plain div/mod arithmetic.
module tb_vga_scan_gen;

  localparam int H_VIS  = 64;
  localparam int H_FP   = 4;
  localparam int H_SYNC = 8;
  localparam int H_BP   = 4;
  localparam int V_VIS  = 24;
  localparam int V_FP   = 2;
  localparam int V_SYNC = 2;
  localparam int V_BP   = 3;
  localparam int H_TOT  = H_VIS + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_VIS + V_FP + V_SYNC + V_BP;
  localparam int FRAME  = H_TOT * V_TOT;
  localparam int HS0    = H_VIS + H_FP;
  localparam int VS0    = V_VIS + V_FP;
  localparam int VISN   = H_VIS * V_VIS;
`ifdef VGA_PIX_DIV2_EN
  localparam int CPP = 2;
`else
  localparam int CPP = 1;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vga_scan_gen_if vif ();

  vga_scan_gen #(
    .H_VIS(H_VIS), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
    .V_VIS(V_VIS), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .vga   (vif)
  );

  int          checks = 0;
  int          errors = 0;
  int          mode = 0;
  logic [23:0] seed = 24'h0;

  function automatic logic [23:0] col_of(int m, int cx, int cy);
    logic [9:0] xv, yv;
    xv = cx[9:0];
    yv = cy[9:0];
    case (m)
      0:       return 24'h3FA34D;
      1:       return {14'b0, xv};
      default: return {xv[7:0] ^ seed[7:0], yv[7:0] ^ seed[15:8],
                       (xv[7:0] + yv[7:0]) ^ seed[23:16]};
    endcase
  endfunction

  // Combinational renderer.
  always_comb vif.color_in = col_of(mode, int'(vif.x), int'(vif.y));

  // Results of the last scan.
  int    bad, hs_low, vs_low, blank_hi, rgb_const, rgb_zero, rgb_xmatch;
  int    ticks, per_bad, hs_period_clk;
  string first_bad;

  // Follows the raster for pixels 0..npix-1 after a reset release, checking
  // every clk sample against the model and gathering per-pixel statistics.
  task automatic scan(input int npix);
    int p, s, ex, ey, qx, qy, last_fall;
    bit last_pe, exp_pe, exp_act, exp_tick, exp_hs, exp_vs, exp_bl;
    logic [23:0] exp_rgb, obs_rgb;
    logic [9:0]  qx10;
    logic        prev_hs;
    bad = 0; hs_low = 0; vs_low = 0; blank_hi = 0; rgb_const = 0; rgb_zero = 0;
    rgb_xmatch = 0; ticks = 0; per_bad = 0; hs_period_clk = 0; first_bad = "";
    p = 0; s = 0; last_pe = 0; last_fall = -1; prev_hs = 1'b1; qx = 0; qy = 0;
    forever begin
      @(negedge clk);
      s++;
      exp_pe   = (CPP == 1) ? 1'b1 : (s % 2 == 1);
      ex       = p % H_TOT;
      ey       = (p / H_TOT) % V_TOT;
      exp_act  = (ex < H_VIS) && (ey < V_VIS);
      exp_tick = last_pe && ex == 0 && ey == V_VIS;
      if (p == 0) begin
        exp_hs = 1; exp_vs = 1; exp_bl = 0; exp_rgb = '0;
      end else begin
        qx      = (p - 1) % H_TOT;
        qy      = ((p - 1) / H_TOT) % V_TOT;
        exp_hs  = !(qx >= HS0 && qx < HS0 + H_SYNC);
        exp_vs  = !(qy >= VS0 && qy < VS0 + V_SYNC);
        exp_bl  = (qx < H_VIS) && (qy < V_VIS);
        exp_rgb = exp_bl ? col_of(mode, qx, qy) : 24'h0;
      end
      obs_rgb = {vif.vga_r, vif.vga_g, vif.vga_b};
      if (vif.x !== ex[9:0] || vif.y !== ey[9:0] || vif.active !== exp_act ||
          vif.pix_en !== exp_pe || vif.frame_tick !== exp_tick ||
          vif.hsync !== exp_hs || vif.vsync !== exp_vs ||
          vif.blank_n !== exp_bl || obs_rgb !== exp_rgb) begin
        bad++;
        if (bad == 1)
          first_bad = $sformatf("s=%0d x=%0d/%0d y=%0d/%0d act=%b/%b pe=%b/%b tick=%b/%b hs=%b/%b vs=%b/%b bl=%b/%b rgb=%h/%h",
                                s, vif.x, ex, vif.y, ey, vif.active, exp_act, vif.pix_en, exp_pe,
                                vif.frame_tick, exp_tick, vif.hsync, exp_hs, vif.vsync, exp_vs,
                                vif.blank_n, exp_bl, obs_rgb, exp_rgb);
      end
      if (exp_pe && p >= 1) begin
        qx10 = qx[9:0];
        if (vif.hsync === 1'b0) hs_low++;
        if (vif.vsync === 1'b0) vs_low++;
        if (vif.blank_n === 1'b1) blank_hi++;
        if (vif.blank_n === 1'b1 && obs_rgb === 24'h3FA34D) rgb_const++;
        if (vif.blank_n === 1'b0 && obs_rgb === 24'h0) rgb_zero++;
        if (vif.blank_n === 1'b1 && obs_rgb === {14'b0, qx10}) rgb_xmatch++;
      end
      if (vif.frame_tick === 1'b1) ticks++;
      if (prev_hs === 1'b1 && vif.hsync === 1'b0) begin
        if (last_fall >= 0) begin
          hs_period_clk = s - last_fall;
          if (s - last_fall != H_TOT * CPP) per_bad++;
        end
        last_fall = s;
      end
      prev_hs = vif.hsync;
      last_pe = exp_pe;
      if (exp_pe) begin
        p++;
        if (p > npix) break;
      end
    end
  endtask

  task automatic restart();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [23:0] rgb;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rgb = {vif.vga_r, vif.vga_g, vif.vga_b};
    checks++; if (vif.x !== 10'd0) begin errors++; $display("FAIL reset_x: got %0d want 0", vif.x); end
    checks++; if (vif.y !== 10'd0) begin errors++; $display("FAIL reset_y: got %0d want 0", vif.y); end
    checks++; if (vif.active !== 1'b1) begin errors++; $display("FAIL reset_active: got %b want 1", vif.active); end
    checks++; if (vif.hsync !== 1'b1) begin errors++; $display("FAIL reset_hsync: got %b want 1", vif.hsync); end
    checks++; if (vif.vsync !== 1'b1) begin errors++; $display("FAIL reset_vsync: got %b want 1", vif.vsync); end
    checks++; if (vif.blank_n !== 1'b0) begin errors++; $display("FAIL reset_blank_n: got %b want 0", vif.blank_n); end
    checks++; if (rgb !== 24'h0) begin errors++; $display("FAIL reset_rgb: got %h want 000000", rgb); end
    checks++; if (vif.frame_tick !== 1'b0) begin errors++; $display("FAIL reset_tick: got %b want 0", vif.frame_tick); end
    checks++; if (vif.pix_en !== 1'b0) begin errors++; $display("FAIL reset_pix_en: got %b want 0", vif.pix_en); end
  endtask

  task automatic test_sync_timing();
    mode = 2; seed = 24'($urandom);
    restart();
    scan(2 * FRAME);
    checks++; if (bad !== 0) begin errors++; $display("FAIL sync_scan: %0d bad samples, want 0; first %s", bad, first_bad); end
    checks++; if (hs_low !== 2 * V_TOT * H_SYNC) begin errors++; $display("FAIL hsync_low_pixels: got %0d want %0d", hs_low, 2 * V_TOT * H_SYNC); end
    checks++; if (vs_low !== 2 * V_SYNC * H_TOT) begin errors++; $display("FAIL vsync_low_pixels: got %0d want %0d", vs_low, 2 * V_SYNC * H_TOT); end
    checks++; if (per_bad !== 0) begin errors++; $display("FAIL line_period: %0d bad periods, want 0", per_bad); end
    checks++; if (hs_period_clk !== H_TOT * CPP) begin errors++; $display("FAIL line_period_clk: got %0d want %0d", hs_period_clk, H_TOT * CPP); end
  endtask

  task automatic test_const_color();
    mode = 0;
    restart();
    scan(FRAME);
    checks++; if (bad !== 0) begin errors++; $display("FAIL const_scan: %0d bad samples, want 0; first %s", bad, first_bad); end
    checks++; if (blank_hi !== VISN) begin errors++; $display("FAIL const_blank_n: got %0d want %0d", blank_hi, VISN); end
    checks++; if (rgb_const !== VISN) begin errors++; $display("FAIL const_rgb: got %0d want %0d", rgb_const, VISN); end
    checks++; if (rgb_zero !== FRAME - VISN) begin errors++; $display("FAIL const_black: got %0d want %0d", rgb_zero, FRAME - VISN); end
  endtask

  task automatic test_x_alignment();
    mode = 1;
    restart();
    scan(FRAME);
    checks++; if (bad !== 0) begin errors++; $display("FAIL xalign_scan: %0d bad samples, want 0; first %s", bad, first_bad); end
    checks++; if (rgb_xmatch !== VISN) begin errors++; $display("FAIL xalign_rgb: got %0d want %0d", rgb_xmatch, VISN); end
  endtask

  task automatic test_frame_tick();
    mode = 2; seed = 24'($urandom);
    restart();
    scan(3 * FRAME);
    checks++; if (bad !== 0) begin errors++; $display("FAIL tick_scan: %0d bad samples, want 0; first %s", bad, first_bad); end
    checks++; if (ticks !== 3) begin errors++; $display("FAIL tick_count: got %0d want 3", ticks); end
  endtask

  task automatic test_async_reset();
    int xr, yr;
    logic [23:0] rgb;
    // Reset in the middle of a visible line.
    mode = 0;
    restart();
    xr = $urandom_range(H_VIS - 1, 1);
    yr = $urandom_range(V_VIS - 1, 0);
    scan(yr * H_TOT + xr);
    checks++; if (bad !== 0) begin errors++; $display("FAIL midline_scan: %0d bad samples, want 0; first %s", bad, first_bad); end
    #2;
    rgb = {vif.vga_r, vif.vga_g, vif.vga_b};
    checks++; if (vif.blank_n !== 1'b1 || rgb !== 24'h3FA34D) begin errors++; $display("FAIL pre_reset_visible: blank_n=%b rgb=%h want 1/3fa34d", vif.blank_n, rgb); end
    rst_n = 1'b0;
    #1;
    rgb = {vif.vga_r, vif.vga_g, vif.vga_b};
    checks++; if (vif.x !== 10'd0 || vif.y !== 10'd0) begin errors++; $display("FAIL async_xy: got %0d,%0d want 0,0", vif.x, vif.y); end
    checks++; if (vif.blank_n !== 1'b0 || rgb !== 24'h0) begin errors++; $display("FAIL async_pixel: blank_n=%b rgb=%h want 0/000000", vif.blank_n, rgb); end
    // Reset while both syncs are low.
    @(negedge clk);
    #1 rst_n = 1'b1;
    xr = $urandom_range(HS0 + H_SYNC - 1, HS0 + 1);
    yr = $urandom_range(VS0 + V_SYNC - 1, VS0);
    scan(yr * H_TOT + xr);
    checks++; if (bad !== 0) begin errors++; $display("FAIL restart_scan: %0d bad samples, want 0; first %s", bad, first_bad); end
    #2;
    checks++; if (vif.hsync !== 1'b0 || vif.vsync !== 1'b0) begin errors++; $display("FAIL pre_reset_sync: hs=%b vs=%b want 0/0", vif.hsync, vif.vsync); end
    rst_n = 1'b0;
    #1;
    checks++; if (vif.hsync !== 1'b1 || vif.vsync !== 1'b1) begin errors++; $display("FAIL async_sync: hs=%b vs=%b want 1/1", vif.hsync, vif.vsync); end
    checks++; if (vif.pix_en !== 1'b0 || vif.frame_tick !== 1'b0 || vif.active !== 1'b1) begin errors++; $display("FAIL async_ctrl: pe=%b tick=%b act=%b want 0/0/1", vif.pix_en, vif.frame_tick, vif.active); end
    @(negedge clk);
    #1 rst_n = 1'b1;
    mode = 2; seed = 24'($urandom);
    scan(FRAME);
    checks++; if (bad !== 0) begin errors++; $display("FAIL post_reset_frame: %0d bad samples, want 0; first %s", bad, first_bad); end
  endtask

  initial begin
    test_reset();
    test_sync_timing();
    test_const_color();
    test_x_alignment();
    test_frame_tick();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
